// File: rtl/fracnet_pkg.sv
// rtl/fracnet_pkg.sv - shared widths, limits and state encoding for the FracNet requant stage
package fracnet_pkg;

   localparam int PROD_W    = 24;
   localparam int ACC_W     = 32;
   localparam int OUT_W     = 16;
   localparam int MAX_BEATS = 256;
   localparam int SHIFT_W   = 4;
   localparam int CNT_W     = $clog2(MAX_BEATS + 1);

   localparam int OUT_MAX   = 32767;
   localparam int OUT_MIN   = -32768;

   typedef enum logic [1:0] {
      ACCUM   = 2'd0,
      REQUANT = 2'd1,
      OUT     = 2'd2
   } state_t;

endpackage

// File: rtl/fracnet_requant_sat.sv
// rtl/fracnet_requant_sat.sv - bias add, round-half-up shift and 16-bit signed saturation
module fracnet_requant_sat
   import fracnet_pkg::*;
(
   input  logic signed [ACC_W-1:0]   i_acc,
   input  logic signed [OUT_W-1:0]   i_bias,
   input  logic        [SHIFT_W-1:0] i_shift,
   output logic signed [OUT_W-1:0]   o_data,
   output logic                      o_sat
);

   // One guard bit above the accumulator so the bias and rounding add cannot wrap.
   localparam logic signed [ACC_W:0] L_MAX = (ACC_W+1)'(OUT_MAX);
   localparam logic signed [ACC_W:0] L_MIN = (ACC_W+1)'(OUT_MIN);

   logic signed [ACC_W:0] w_round;
   logic signed [ACC_W:0] w_t;
   logic signed [ACC_W:0] w_r;

   // Add bias and half-LSB, shift arithmetically, then clip into the output range.
   always_comb begin
      w_round = '0;
      if (i_shift != '0) begin
         w_round[i_shift - 1'b1] = 1'b1;
      end
      w_t = {i_acc[ACC_W-1], i_acc}
          + {{(ACC_W+1-OUT_W){i_bias[OUT_W-1]}}, i_bias}
          + w_round;
      w_r = w_t >>> i_shift;
      if (w_r > L_MAX) begin
         o_data = OUT_W'(OUT_MAX);
         o_sat  = 1'b1;
      end else if (w_r < L_MIN) begin
         o_data = OUT_W'(OUT_MIN);
         o_sat  = 1'b1;
      end else begin
         o_data = w_r[OUT_W-1:0];
         o_sat  = 1'b0;
      end
   end

endmodule

// File: rtl/fracnet_mul_acc_requant.sv
// rtl/fracnet_mul_acc_requant.sv - accumulate a product group, requantise and hand off one activation
module fracnet_mul_acc_requant
   import fracnet_pkg::*;
(
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic signed [PROD_W-1:0]  in_prod,
   input  logic                      in_last,
   input  logic signed [OUT_W-1:0]   in_bias,
   input  logic        [SHIFT_W-1:0] in_shift,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic signed [OUT_W-1:0]   out_data,
   output logic                      out_sat,
   output logic                      len_err
);

   state_t                    r_state;
   state_t                    w_next;
   logic signed [ACC_W-1:0]   r_acc;
   logic        [CNT_W-1:0]   r_cnt;
   logic signed [OUT_W-1:0]   r_bias;
   logic        [SHIFT_W-1:0] r_shift;
   logic                      r_out_valid;
   logic signed [OUT_W-1:0]   r_out_data;
   logic                      r_out_sat;
   logic                      r_len_err;

   logic                      w_accept;
   logic                      w_close;
   logic signed [ACC_W-1:0]   w_prod_ext;
   logic signed [OUT_W-1:0]   w_rq_data;
   logic                      w_rq_sat;

   assign in_ready   = (r_state == ACCUM);
   assign w_accept   = in_valid && in_ready;
   assign w_close    = w_accept && (in_last || (r_cnt == CNT_W'(MAX_BEATS - 1)));
   assign w_prod_ext = {{(ACC_W-PROD_W){in_prod[PROD_W-1]}}, in_prod};

   assign out_valid  = r_out_valid;
   assign out_data   = r_out_data;
   assign out_sat    = r_out_sat;
   assign len_err    = r_len_err;

   fracnet_requant_sat u_requant (
      .i_acc   (r_acc),
      .i_bias  (r_bias),
      .i_shift (r_shift),
      .o_data  (w_rq_data),
      .o_sat   (w_rq_sat)
   );

   // Next-state: close the group on last or length limit, one requant cycle, hold until taken.
   always_comb begin
      w_next = r_state;
      case (r_state)
         ACCUM:   if (w_close)   w_next = REQUANT;
         REQUANT:                w_next = OUT;
         OUT:     if (out_ready) w_next = ACCUM;
         default:                w_next = ACCUM;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= ACCUM;
      end else begin
         r_state <= w_next;
      end
   end

   // Accumulator, beat counter, captured group parameters and registered result.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc       <= '0;
         r_cnt       <= '0;
         r_bias      <= '0;
         r_shift     <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_len_err   <= 1'b0;
      end else begin
         case (r_state)
            ACCUM: begin
               if (w_accept) begin
                  // The first beat loads so no separate clear cycle is needed between groups.
                  r_acc <= (r_cnt == '0) ? w_prod_ext : (r_acc + w_prod_ext);
                  r_cnt <= r_cnt + CNT_W'(1);
               end
               if (w_close) begin
                  r_bias    <= in_bias;
                  r_shift   <= in_shift;
                  r_len_err <= ~in_last;
               end
            end
            REQUANT: begin
               r_out_data  <= w_rq_data;
               r_out_sat   <= w_rq_sat;
               r_out_valid <= 1'b1;
            end
            OUT: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_cnt       <= '0;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fracnet_mul_acc_requant.sv
// tb/tb_fracnet_mul_acc_requant.sv - directed self-checking bench for fracnet_mul_acc_requant
module tb_fracnet_mul_acc_requant;

   logic               clk = 1'b0;
   logic               reset;
   logic               in_valid;
   logic               in_ready;
   logic signed [23:0] in_prod;
   logic               in_last;
   logic signed [15:0] in_bias;
   logic        [3:0]  in_shift;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_data;
   logic               out_sat;
   logic               len_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   fracnet_mul_acc_requant dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_prod   (in_prod),
      .in_last   (in_last),
      .in_bias   (in_bias),
      .in_shift  (in_shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .len_err   (len_err)
   );

   // Drive one beat across one rising edge; inputs change 1ns after the edge.
   task automatic beat(input logic signed [23:0] p, input logic last,
                       input logic signed [15:0] b, input logic [3:0] s);
      in_valid = 1'b1; in_prod = p; in_last = last; in_bias = b; in_shift = s;
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0; in_prod = '0;
   endtask

   task automatic wait_out(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (out_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic take();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_prod = '0;
      in_bias = '0; in_shift = '0; out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_out_data: got %0d want 0", out_data); end
      checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b want 0", len_err); end
   endtask

   task automatic test_basic();
      beat(24'sd100, 1'b0, 16'sd0, 4'd0);
      beat(-24'sd20, 1'b0, 16'sd0, 4'd0);
      beat(24'sd7,   1'b1, 16'sd0, 4'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_t1_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_t1_ready: got %b want 0", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_t2_valid: got %b want 1", out_valid); end
      checks++; if (out_data !== 16'sd87) begin errors++; $display("FAIL basic_data: got %0d want 87", out_data); end
      checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL basic_sat: got %b want 0", out_sat); end
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL basic_len_err: got %b want 0", len_err); end
      take();
   endtask

   task automatic test_rounding();
      logic signed [23:0] prods [5] = '{24'sd5, -24'sd5, 24'sd1000, 24'sd7, -24'sd6};
      logic signed [15:0] biases[5] = '{16'sd0, 16'sd0, -16'sd8, 16'sd0, 16'sd0};
      logic        [3:0]  shifts[5] = '{4'd1, 4'd1, 4'd3, 4'd2, 4'd2};
      logic signed [15:0] exps  [5] = '{16'sd3, -16'sd2, 16'sd124, 16'sd2, -16'sd1};
      bit ok;
      for (int i = 0; i < 5; i++) begin
         beat(prods[i], 1'b1, biases[i], shifts[i]);
         wait_out(ok);
         checks++; if (!ok) begin errors++; $display("FAIL round_timeout[%0d]: got no out_valid want out_valid", i); end
         checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL round_data[%0d]: got %0d want %0d", i, out_data, exps[i]); end
         checks++; if (out_sat !== 1'b0) begin errors++; $display("FAIL round_sat[%0d]: got %b want 0", i, out_sat); end
         take();
      end
   endtask

   task automatic test_saturation();
      logic signed [23:0] prods[6] = '{24'sd8388607, -24'sd8388608, 24'sd32767, 24'sd32768, -24'sd32768, -24'sd32769};
      int                 nbeat[6] = '{2, 2, 1, 1, 1, 1};
      logic        [3:0]  shifts[6] = '{4'd4, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
      logic signed [15:0] exps [6] = '{16'sd32767, -16'sd32768, 16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768};
      logic               esat [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      bit ok;
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k < nbeat[i]; k++) begin
            beat(prods[i], (k == nbeat[i] - 1), 16'sd0, shifts[i]);
         end
         wait_out(ok);
         checks++; if (!ok) begin errors++; $display("FAIL sat_timeout[%0d]: got no out_valid want out_valid", i); end
         checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL sat_data[%0d]: got %0d want %0d", i, out_data, exps[i]); end
         checks++; if (out_sat !== esat[i]) begin errors++; $display("FAIL sat_flag[%0d]: got %b want %b", i, out_sat, esat[i]); end
         take();
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      beat(24'sd11, 1'b0, 16'sd0, 4'd0);
      beat(24'sd22, 1'b1, 16'sd0, 4'd0);
      wait_out(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_timeout: got no out_valid want out_valid"); end
      // Offer a stray beat while stalled; it must never be accepted.
      in_valid = 1'b1; in_prod = 24'sd1000; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++; if (out_data !== 16'sd33 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold[%0d]: got data=%0d valid=%b want data=33 valid=1", i, out_data, out_valid); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      end
      take();
      in_valid = 1'b0; in_last = 1'b0; in_prod = '0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after_valid: got %b want 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_after_ready: got %b want 1", in_ready); end
      beat(24'sd3, 1'b1, 16'sd0, 4'd0);
      wait_out(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bp_next_timeout: got no out_valid want out_valid"); end
      checks++; if (out_data !== 16'sd3) begin errors++; $display("FAIL bp_next_data: got %0d want 3", out_data); end
      take();
   endtask

   task automatic test_reset_mid();
      bit ok;
      beat(24'sd50, 1'b0, 16'sd0, 4'd0);
      beat(24'sd60, 1'b0, 16'sd0, 4'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_during: got %b want 0", out_valid); end
      reset = 1'b0;
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_after: got valid=%b ready=%b want valid=0 ready=1", out_valid, in_ready); end
      beat(24'sd9, 1'b1, 16'sd0, 4'd0);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_early: got %b want 0", out_valid); end
      wait_out(ok);
      checks++; if (!ok) begin errors++; $display("FAIL rst_mid_timeout: got no out_valid want out_valid"); end
      checks++; if (out_data !== 16'sd9) begin errors++; $display("FAIL rst_mid_data: got %0d want 9", out_data); end
      take();
   endtask

   task automatic test_len_err();
      bit ok;
      for (int i = 0; i < 256; i++) begin
         beat(24'sd1, 1'b0, 16'sd0, 4'd0);
      end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL len_closed: got in_ready=%b want 0", in_ready); end
      wait_out(ok);
      checks++; if (!ok) begin errors++; $display("FAIL len_timeout: got no out_valid want out_valid"); end
      checks++; if (out_data !== 16'sd256) begin errors++; $display("FAIL len_data: got %0d want 256", out_data); end
      checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len_flag: got %b want 1", len_err); end
      take();
      beat(24'sd4, 1'b1, 16'sd0, 4'd0);
      wait_out(ok);
      checks++; if (!ok) begin errors++; $display("FAIL len_next_timeout: got no out_valid want out_valid"); end
      checks++; if (out_data !== 16'sd4) begin errors++; $display("FAIL len_next_data: got %0d want 4", out_data); end
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len_next_flag: got %b want 0", len_err); end
      take();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_reset_mid();
      test_len_err();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
